// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared SHA-256 definitions: word/block geometry, the schedule FSM state
// type, and the four SHA-256 sigma functions used by the datapath stages.
// -----------------------------------------------------------------------------
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int SCHED_LEN   = 64;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } sched_state_t;

  // Small sigma for the message schedule: ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t sigma0(input word_t x);
    sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // Small sigma for the message schedule: ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t sigma1(input word_t x);
    sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  // Big sigma used by compression: ROTR2 ^ ROTR13 ^ ROTR22
  function automatic word_t big_sigma0(input word_t x);
    big_sigma0 = {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  // Big sigma used by compression: ROTR6 ^ ROTR11 ^ ROTR25
  function automatic word_t big_sigma1(input word_t x);
    big_sigma1 = {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

endpackage

// File: rtl/message_schedule_calc.sv
// -----------------------------------------------------------------------------
// message_schedule_calc
// Combinational next-word generator for the SHA-256 schedule window.
//   w0, w1, w9, w14 : window taps (window[0], [1], [9], [14])
//   w_new           : new window[15] = sigma1(w14) + w9 + sigma0(w1) + w0 mod 2^32
// The four-operand add is balanced as two pairwise adds feeding a final add.
// -----------------------------------------------------------------------------
module message_schedule_calc
  import sha256_pkg::*;
(
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  input  logic [31:0] w9,
  input  logic [31:0] w14,
  output logic [31:0] w_new
);

  logic [31:0] sum_a_s;
  logic [31:0] sum_b_s;

  assign sum_a_s = sigma1(w14) + w9;
  assign sum_b_s = sigma0(w1) + w0;
  assign w_new   = sum_a_s + sum_b_s;

endmodule

// File: rtl/message_schedule.sv
// -----------------------------------------------------------------------------
// message_schedule
// SHA-256 message-schedule expansion. Accepts one padded 512-bit block per
// input handshake and emits W0..W63 one word per output handshake.
//   clk, nrst, sync_rst : clock, async active-low reset, sync reset
//   en                  : global enable, 0 freezes all state and handshakes
//   data_in[511:0]      : block, M0 in [511:480] ... M15 in [31:0]
//   data_in_last        : block is the final one of the message
//   data_in_valid/ready : input handshake
//   data_out[31:0]      : schedule word Wt
//   data_out_index[5:0] : t of data_out
//   data_out_last       : Wt belongs to a final block
//   data_out_valid/ready: output handshake
// -----------------------------------------------------------------------------
module message_schedule
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic         sync_rst,
  input  logic [511:0] data_in,
  input  logic         data_in_last,
  input  logic         data_in_valid,
  output logic         data_in_ready,
  output logic [31:0]  data_out,
  output logic [5:0]   data_out_index,
  output logic         data_out_last,
  output logic         data_out_valid,
  input  logic         data_out_ready
);

  sched_state_t        state_r, state_s;
  logic                rdy_r, rdy_s;
  logic                vld_r, vld_s;
  logic [31:0]         dout_r, dout_s;
  logic [5:0]          idx_r, idx_s;
  logic                dlast_r, dlast_s;
  logic [5:0]          t_r, t_s;
  logic                last_r, last_s;
  logic [15:0][31:0]   win_r, win_s;
  logic [31:0]         w_new_s;
  logic                slot_free_s;

  assign data_in_ready  = rdy_r & en;
  assign data_out_valid = vld_r & en;
  assign data_out       = dout_r;
  assign data_out_index = idx_r;
  assign data_out_last  = dlast_r;

  // A word may be registered when nothing is pending or the pending one leaves now
  assign slot_free_s = ~vld_r | data_out_ready;

  message_schedule_calc u_calc (
    .w0    (win_r[0]),
    .w1    (win_r[1]),
    .w9    (win_r[9]),
    .w14   (win_r[14]),
    .w_new (w_new_s)
  );

  // Next-state and datapath update for the load/expand FSM
  always_comb begin
    state_s = state_r;
    rdy_s   = rdy_r;
    vld_s   = vld_r;
    dout_s  = dout_r;
    idx_s   = idx_r;
    dlast_s = dlast_r;
    t_s     = t_r;
    last_s  = last_r;
    win_s   = win_r;
    if (en) begin
      case (state_r)
        ST_IDLE: begin
          rdy_s = 1'b1;
          // W63 of the previous block may still be pending here
          if (vld_r && data_out_ready) begin
            vld_s = 1'b0;
          end else begin
            vld_s = vld_r;
          end
          if (data_in_valid && rdy_r) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
              win_s[i] = data_in[511-32*i -: 32];
            end
            last_s  = data_in_last;
            t_s     = 6'd0;
            rdy_s   = 1'b0;
            state_s = ST_EXPAND;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_EXPAND: begin
          if (slot_free_s) begin
            dout_s          = win_r[0];
            idx_s           = t_r;
            dlast_s         = last_r;
            vld_s           = 1'b1;
            win_s[14:0]     = win_r[15:1];
            win_s[15]       = w_new_s;
            t_s             = t_r + 6'd1;
            if (t_r == 6'(SCHED_LEN - 1)) begin
              state_s = ST_IDLE;
              rdy_s   = 1'b1;
            end else begin
              state_s = ST_EXPAND;
            end
          end else begin
            state_s = ST_EXPAND;
          end
        end
        default: begin
          state_s = ST_IDLE;
          rdy_s   = 1'b1;
          vld_s   = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and datapath registers; sync_rst mirrors nrst on the next edge
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= ST_IDLE;
      rdy_r   <= 1'b1;
      vld_r   <= 1'b0;
      dout_r  <= 32'h0000_0000;
      idx_r   <= 6'd0;
      dlast_r <= 1'b0;
      t_r     <= 6'd0;
      last_r  <= 1'b0;
      win_r   <= '0;
    end else if (sync_rst) begin
      state_r <= ST_IDLE;
      rdy_r   <= 1'b1;
      vld_r   <= 1'b0;
      dout_r  <= 32'h0000_0000;
      idx_r   <= 6'd0;
      dlast_r <= 1'b0;
      t_r     <= 6'd0;
      last_r  <= 1'b0;
      win_r   <= '0;
    end else begin
      state_r <= state_s;
      rdy_r   <= rdy_s;
      vld_r   <= vld_s;
      dout_r  <= dout_s;
      idx_r   <= idx_s;
      dlast_r <= dlast_s;
      t_r     <= t_s;
      last_r  <= last_s;
      win_r   <= win_s;
    end
  end

endmodule

// File: tb/tb_message_schedule.sv
// -----------------------------------------------------------------------------
// tb_message_schedule
// Directed bench for message_schedule: "abc" block with known schedule words,
// backpressure, back-to-back blocks, async/sync reset and enable freeze.
// -----------------------------------------------------------------------------
module tb_message_schedule;

  logic         clk;
  logic         nrst;
  logic         en;
  logic         sync_rst;
  logic [511:0] data_in;
  logic         data_in_last;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [31:0]  data_out;
  logic [5:0]   data_out_index;
  logic         data_out_last;
  logic         data_out_valid;
  logic         data_out_ready;

  int err_cnt;
  int chk_cnt;
  int cyc;
  bit bp_en;

  logic [31:0] qw[$];
  logic [5:0]  qi[$];
  logic        ql[$];

  logic [31:0] exp_a [64];
  logic [31:0] exp_b [64];

  logic [511:0] blk_abc;
  logic [511:0] blk_b;

  logic        hold_prev;
  logic [31:0] word_prev;
  logic [5:0]  idx_prev;

  message_schedule dut (
    .clk            (clk),
    .nrst           (nrst),
    .en             (en),
    .sync_rst       (sync_rst),
    .data_in        (data_in),
    .data_in_last   (data_in_last),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_index (data_out_index),
    .data_out_last  (data_out_last),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: always 1 unless the backpressure phase is active
  always @(posedge clk) begin
    int r;
    #1;
    r = $urandom_range(0, 1);
    data_out_ready = bp_en ? r[0] : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Monitor: record every word that will transfer at the coming edge
  always @(negedge clk) begin
    if (hold_prev && data_out_valid) begin
      check("stable_word", data_out, word_prev);
      check("stable_idx", {26'd0, data_out_index}, {26'd0, idx_prev});
    end
    if (data_out_valid && data_out_ready) begin
      qw.push_back(data_out);
      qi.push_back(data_out_index);
      ql.push_back(data_out_last);
    end
    hold_prev = data_out_valid && !data_out_ready;
    word_prev = data_out;
    idx_prev  = data_out_index;
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule built from the textbook recurrence
  task automatic build_model(input logic [511:0] blk, output logic [31:0] w [64]);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
  endtask

  task automatic clear_q();
    qw.delete(); qi.delete(); ql.delete();
  endtask

  task automatic send_block(input logic [511:0] blk, input logic lst, input bit hold, output int acc_cyc);
    int budget;
    @(posedge clk); #1;
    data_in = blk; data_in_last = lst; data_in_valid = 1'b1;
    budget = 300;
    @(negedge clk);
    while (!data_in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("accept_timeout", {31'd0, data_in_ready}, 32'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!hold) data_in_valid = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int budget;
    budget = 3000;
    while (qw.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("word_count", qw.size(), n);
  endtask

  task automatic wait_index(input logic [5:0] idx);
    int budget;
    budget = 300;
    @(negedge clk);
    while (!(data_out_valid && data_out_index == idx) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("index_reach", {26'd0, data_out_index}, {26'd0, idx});
  endtask

  task automatic check_seq(input int base, input logic [31:0] w [64], input logic lst);
    for (int i = 0; i < 64; i++) begin
      if (base + i < qw.size()) begin
        check($sformatf("word[%0d]", i), qw[base+i], w[i]);
        check($sformatf("idx[%0d]", i), {26'd0, qi[base+i]}, i);
        check($sformatf("last[%0d]", i), {31'd0, ql[base+i]}, {31'd0, lst});
      end else begin
        check($sformatf("missing[%0d]", i), qw.size(), base + 64);
      end
    end
  endtask

  initial begin
    int a_cyc, b_cyc;
    err_cnt = 0; chk_cnt = 0; cyc = 0; bp_en = 1'b0;
    hold_prev = 1'b0; word_prev = 32'h0; idx_prev = 6'd0;
    nrst = 1'b0; en = 1'b1; sync_rst = 1'b0;
    data_in = '0; data_in_last = 1'b0; data_in_valid = 1'b0; data_out_ready = 1'b1;

    blk_abc = {32'h61626380, 448'h0, 32'h00000018};
    for (int i = 0; i < 16; i++) blk_b[511-32*i -: 32] = 32'h01234567 * (i + 1) + 32'h9E3779B9;
    build_model(blk_abc, exp_a);
    build_model(blk_b, exp_b);

    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_ready", {31'd0, data_in_ready}, 32'd1);
    check("rst_valid", {31'd0, data_out_valid}, 32'd0);
    check("rst_data", data_out, 32'h0);
    check("rst_index", {26'd0, data_out_index}, 32'd0);
    check("rst_last", {31'd0, data_out_last}, 32'd0);

    // Test 1: "abc", ready tied high, 64 consecutive valid cycles
    clear_q();
    send_block(blk_abc, 1'b1, 1'b0, a_cyc);
    @(negedge clk);
    check("t1_pre_valid", {31'd0, data_out_valid}, 32'd0);
    check("t1_busy_ready", {31'd0, data_in_ready}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check("t1_consec_valid", {31'd0, data_out_valid}, 32'd1);
      check("t1_consec_idx", {26'd0, data_out_index}, i);
    end
    @(negedge clk);
    check("t1_post_valid", {31'd0, data_out_valid}, 32'd0);
    check("t1_post_ready", {31'd0, data_in_ready}, 32'd1);
    wait_words(64);
    if (qw.size() >= 64) begin
      check("hand_w0", qw[0], 32'h61626380);
      check("hand_w15", qw[15], 32'h00000018);
      check("hand_w16", qw[16], 32'h61626380);
      check("hand_w17", qw[17], 32'h000F0000);
      check("hand_w63", qw[63], 32'h12B1EDEB);
    end else begin
      check("hand_count", qw.size(), 64);
    end
    check_seq(0, exp_a, 1'b1);

    // Test 2: same block under random backpressure
    clear_q();
    bp_en = 1'b1;
    send_block(blk_abc, 1'b1, 1'b0, a_cyc);
    wait_words(64);
    bp_en = 1'b0;
    repeat (4) @(negedge clk);
    check("t2_extra_words", qw.size(), 64);
    check_seq(0, exp_a, 1'b1);

    // Test 3: back-to-back blocks, upstream valid held high
    clear_q();
    send_block(blk_b, 1'b0, 1'b1, a_cyc);
    send_block(blk_abc, 1'b1, 1'b0, b_cyc);
    check("t3_accept_gap", b_cyc - a_cyc, 32'd65);
    wait_words(128);
    check_seq(0, exp_b, 1'b0);
    check_seq(64, exp_a, 1'b1);
    repeat (3) @(negedge clk);

    // Test 4: async reset at t=30
    clear_q();
    send_block(blk_abc, 1'b1, 1'b0, a_cyc);
    wait_index(6'd30);
    #1 nrst = 1'b0;
    #1;
    check("t4_async_valid", {31'd0, data_out_valid}, 32'd0);
    check("t4_async_index", {26'd0, data_out_index}, 32'd0);
    @(posedge clk); #1 nrst = 1'b1;
    @(negedge clk);
    check("t4_rel_ready", {31'd0, data_in_ready}, 32'd1);
    check("t4_rel_valid", {31'd0, data_out_valid}, 32'd0);
    clear_q();
    send_block(blk_abc, 1'b1, 1'b0, a_cyc);
    wait_words(64);
    check_seq(0, exp_a, 1'b1);
    repeat (3) @(negedge clk);

    // Test 5: sync reset at t=10, then enable freeze at t=20
    clear_q();
    send_block(blk_abc, 1'b1, 1'b0, a_cyc);
    wait_index(6'd10);
    @(posedge clk); #1 sync_rst = 1'b1;
    @(posedge clk); #1 sync_rst = 1'b0;
    check("t5_srst_valid", {31'd0, data_out_valid}, 32'd0);
    check("t5_srst_ready", {31'd0, data_in_ready}, 32'd1);
    check("t5_srst_index", {26'd0, data_out_index}, 32'd0);
    check("t5_srst_data", data_out, 32'h0);
    check("t5_srst_last", {31'd0, data_out_last}, 32'd0);
    clear_q();
    send_block(blk_b, 1'b1, 1'b0, a_cyc);
    wait_index(6'd19);
    @(posedge clk); #1 en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_en0_valid", {31'd0, data_out_valid}, 32'd0);
      check("t5_en0_ready", {31'd0, data_in_ready}, 32'd0);
      check("t5_en0_index", {26'd0, data_out_index}, 32'd20);
    end
    @(posedge clk); #1 en = 1'b1;
    @(negedge clk);
    check("t5_resume_index", {26'd0, data_out_index}, 32'd20);
    wait_words(64);
    check_seq(0, exp_b, 1'b1);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
